// File: rtl/txn_receiver.sv
// Checksummed transaction receiver: header, NUM_DATA payload beats, checksum.
// Results queue in a first-word-fall-through FIFO; event counters saturate.
module txn_receiver #(
    parameter int DATA_W   = 32,
    parameter int NUM_DATA = 8,
    parameter int DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sop,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_hdr,
    output logic              out_ok,
    output logic [15:0]       good_cnt,
    output logic [15:0]       bad_cnt,
    output logic [15:0]       err_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_HDR  = 2'd0,
        S_DATA = 2'd1,
        S_CSM  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [7:0]        r_cnt;
    logic [DATA_W-1:0] r_hdr;
    logic [DATA_W-1:0] r_xor;
    logic [DATA_W:0]   r_mem [DEPTH];
    logic [AW:0]       r_wp;
    logic [AW:0]       r_rp;
    logic [15:0]       r_good;
    logic [15:0]       r_bad;
    logic [15:0]       r_err;

    logic              w_acc;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_ld_hdr;
    logic              w_add;
    logic              w_err;
    logic              w_good;
    logic              w_bad;
    logic              w_ok;
    logic [DATA_W:0]   w_head;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Pointers differ only in the wrap bit when the FIFO is full
    assign w_full   = (r_wp ^ r_rp) == {1'b1, {AW{1'b0}}};
    assign w_empty  = (r_wp == r_rp);
    assign w_pop    = out_valid & out_ready;
    assign w_head   = r_mem[r_rp[AW-1:0]];
    assign w_ok     = (in_data == r_xor);
    assign in_ready = (r_state == S_CSM) ? !w_full : 1'b1;
    assign w_acc    = in_valid & in_ready;

    assign out_valid = !w_empty;
    assign out_hdr   = w_empty ? '0 : w_head[DATA_W:1];
    assign out_ok    = w_empty ? 1'b0 : w_head[0];
    assign good_cnt  = r_good;
    assign bad_cnt   = r_bad;
    assign err_cnt   = r_err;

    always_comb begin
        w_next   = r_state;
        w_push   = 1'b0;
        w_ld_hdr = 1'b0;
        w_add    = 1'b0;
        w_err    = 1'b0;
        w_good   = 1'b0;
        w_bad    = 1'b0;
        if (w_acc) begin
            unique case (r_state)
                S_HDR: begin
                    if (in_sop) begin
                        w_ld_hdr = 1'b1;
                        w_next   = S_DATA;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                S_DATA: begin
                    if (in_sop) begin
                        w_err    = 1'b1;
                        w_ld_hdr = 1'b1;
                        w_next   = S_DATA;
                    end else begin
                        w_add = 1'b1;
                        if (r_cnt == 8'(NUM_DATA - 1))
                            w_next = S_CSM;
                    end
                end
                S_CSM: begin
                    if (in_sop) begin
                        w_err    = 1'b1;
                        w_ld_hdr = 1'b1;
                        w_next   = S_DATA;
                    end else begin
                        w_push = 1'b1;
                        w_good = w_ok;
                        w_bad  = !w_ok;
                        w_next = S_HDR;
                    end
                end
                default: w_next = S_HDR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_HDR;
            r_cnt   <= '0;
            r_xor   <= '0;
            r_hdr   <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_good  <= '0;
            r_bad   <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_next;
            if (w_ld_hdr) begin
                r_hdr <= in_data;
                r_xor <= in_data;
                r_cnt <= '0;
            end else if (w_add) begin
                r_xor <= r_xor ^ in_data;
                r_cnt <= r_cnt + 8'd1;
            end else if (w_push) begin
                r_cnt <= '0;
            end
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_pop)
                r_rp <= r_rp + 1'b1;
            if (w_good)
                r_good <= sat_inc(r_good);
            if (w_bad)
                r_bad <= sat_inc(r_bad);
            if (w_err)
                r_err <= sat_inc(r_err);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp[AW-1:0]] <= {r_hdr, w_ok};
    end
endmodule
